// File: rtl/mem_slave.sv
// Memory-mapped slave RAM: byte-enabled writes, programmable wait states, fixed-latency in-order reads.
// Optional MEM_SLAVE_BOUNDS_CHK_EN: out-of-range writes dropped, out-of-range reads return 32'hDEADBEEF.
module mem_slave #(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 2,
  parameter int WAIT_CYCLES  = 0,
  parameter int MAX_PENDING  = 2
) (
  input  logic        clk,
  input  logic        rest,
  input  logic [31:0] s_address,
  input  logic [3:0]  s_byteEnable,
  input  logic        s_read,
  output logic [31:0] s_readData,
  input  logic        s_write,
  input  logic [31:0] s_writeData,
  output logic        s_waitRequest,
  output logic        s_readDataValid
);

  localparam int PW    = $clog2(MAX_PENDING + 1);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [2:0]            wcnt;
  logic [PW-1:0]         pending;
  logic                  cmd, waitTerm, fullTerm, accept, wrAcc, rdAcc, inRange;
  logic [ADDR_WIDTH-1:0] wordIdx;
  logic [31:0]           memWord, rdWord;
  logic                  unusedAddrBits;

  assign wordIdx = s_address[ADDR_WIDTH+1:2];

`ifdef MEM_SLAVE_BOUNDS_CHK_EN
  assign inRange        = (s_address[31:ADDR_WIDTH+2] == '0);
  assign rdWord         = inRange ? memWord : 32'hDEADBEEF;
  assign unusedAddrBits = ^s_address[1:0];
`else
  assign inRange        = 1'b1;
  assign rdWord         = memWord;
  assign unusedAddrBits = ^{s_address[1:0], s_address[31:ADDR_WIDTH+2]};
`endif

  always_comb begin
    cmd           = s_read | s_write;
    waitTerm      = cmd && (wcnt != 3'(WAIT_CYCLES));
    fullTerm      = s_read && (pending == PW'(MAX_PENDING));
    s_waitRequest = !rest || waitTerm || fullTerm;
    accept        = cmd && !s_waitRequest;
    // A read colliding with a write is dropped; the write wins.
    wrAcc         = accept && s_write && inRange;
    rdAcc         = accept && s_read && !s_write;
  end

  // One byte-wide RAM per lane so byte enables map onto independent write ports.
  for (genvar b = 0; b < 4; b++) begin : lane
    logic [7:0] ram [DEPTH];
    always_ff @(posedge clk) begin
      if (wrAcc && s_byteEnable[b])
        ram[wordIdx] <= s_writeData[8*b +: 8];
    end
    assign memWord[8*b +: 8] = ram[wordIdx];
  end

  always_ff @(posedge clk) begin
    if (!rest) begin
      wcnt    <= '0;
      pending <= '0;
    end else begin
      // A pending-full stall leaves wcnt parked at WAIT_CYCLES, so no re-wait.
      if (!cmd || accept)
        wcnt <= '0;
      else if (waitTerm)
        wcnt <= wcnt + 3'd1;

      case ({rdAcc, s_readDataValid})
        2'b10:   pending <= pending + PW'(1);
        2'b01:   pending <= pending - PW'(1);
        default: pending <= pending;
      endcase
    end
  end

  // Stage 0 is the synchronous RAM read; each stage only loads data when valid,
  // so the final stage holds the last returned word between pulses.
  for (genvar s = 0; s < READ_LATENCY; s++) begin : stg
    logic        vld, inVld;
    logic [31:0] data, inData;
    if (s == 0) begin : head
      assign inVld  = rdAcc;
      assign inData = rdWord;
    end else begin : body
      assign inVld  = stg[s-1].vld;
      assign inData = stg[s-1].data;
    end
    always_ff @(posedge clk) begin
      if (!rest) begin
        vld  <= 1'b0;
        data <= '0;
      end else begin
        vld <= inVld;
        if (inVld)
          data <= inData;
      end
    end
  end

  assign s_readDataValid = stg[READ_LATENCY-1].vld;
  assign s_readData      = stg[READ_LATENCY-1].data;

endmodule

// File: tb/tb_mem_slave.sv
// Self-checking bench for mem_slave: three configurations driven by directed and random traffic
// against a transaction-level model (word array plus accept/return-edge arithmetic).
module tb_mem_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rest   [3];
  logic [31:0] addr   [3];
  logic [3:0]  be     [3];
  logic        rd     [3];
  logic        wr     [3];
  logic [31:0] wdata  [3];
  logic [31:0] rdata  [3];
  logic        wreq   [3];
  logic        rvalid [3];

  // Instance 0: defaults; 1: three wait states; 2: latency 4 with two outstanding reads.
  for (genvar g = 0; g < 3; g++) begin : dut
    mem_slave #(
      .ADDR_WIDTH  (10),
      .READ_LATENCY(g == 2 ? 4 : 2),
      .WAIT_CYCLES (g == 1 ? 3 : 0),
      .MAX_PENDING (2)
    ) u (
      .clk            (clk),
      .rest           (rest[g]),
      .s_address      (addr[g]),
      .s_byteEnable   (be[g]),
      .s_read         (rd[g]),
      .s_readData     (rdata[g]),
      .s_write        (wr[g]),
      .s_writeData    (wdata[g]),
      .s_waitRequest  (wreq[g]),
      .s_readDataValid(rvalid[g])
    );
  end

  function automatic int latOf(int s);
    return (s == 2) ? 4 : 2;
  endfunction

  function automatic int waitOf(int s);
    return (s == 1) ? 3 : 0;
  endfunction

  localparam int MAXP = 2;

  int nChecks = 0;
  int nErrors = 0;

  task automatic checkVal(string tag, logic [31:0] got, logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {int sel; logic [31:0] data; int due;} rd_t;
  typedef struct {int sel; int acc;} acc_t;
  rd_t         expQ[$];
  acc_t        accQ[$];
  logic [31:0] mdl [3][1024];

  function automatic bit addrOk(logic [31:0] a);
`ifdef MEM_SLAVE_BOUNDS_CHK_EN
    return a[31:12] == 20'h0;
`else
    return a[31:12] == a[31:12];
`endif
  endfunction

  // Reads outstanding at edge e: accepted before e and not yet retired by the return at acc+latency.
  function automatic int pendAt(int s, int e);
    int n = 0;
    foreach (accQ[i])
      if (accQ[i].sel == s && accQ[i].acc < e && e <= accQ[i].acc + latOf(s)) n++;
    return n;
  endfunction

  task automatic flush(int s);
    for (int i = expQ.size() - 1; i >= 0; i--) if (expQ[i].sel == s) expQ.delete(i);
    for (int i = accQ.size() - 1; i >= 0; i--) if (accQ[i].sel == s) accQ.delete(i);
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called #1 after a rising edge; holds the command until accepted, returns #1 after the accept edge.
  task automatic issue(int s, bit r, bit w, logic [31:0] a, logic [3:0] b, logic [31:0] d);
    int p, e, n;
    int idx;
    p = cyc + 1;
    e = p + waitOf(s);
    while (r && pendAt(s, e) >= MAXP) e++;
    addr[s] = a; be[s] = b; rd[s] = r; wr[s] = w; wdata[s] = d;
    for (n = 0; n < 64; n++) begin
      @(negedge clk);
      if (!wreq[s]) break;
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    checkVal($sformatf("wait s%0d r%0d w%0d a%h", s, r, w, a), n, e - p);
    rd[s] = 1'b0; wr[s] = 1'b0;
    idx = int'(a[11:2]);
    if (w) begin
      if (addrOk(a))
        for (int k = 0; k < 4; k++) if (b[k]) mdl[s][idx][8*k +: 8] = d[8*k +: 8];
    end else if (r) begin
      accQ.push_back('{sel: s, acc: e});
      expQ.push_back('{sel: s, data: addrOk(a) ? mdl[s][idx] : 32'hDEADBEEF, due: e + latOf(s)});
    end
  endtask

  always @(negedge clk) begin
    for (int s = 0; s < 3; s++) begin
      if (rvalid[s] === 1'b1) begin
        int found;
        found = -1;
        foreach (expQ[i]) if (found < 0 && expQ[i].sel == s) found = i;
        if (found < 0) checkVal($sformatf("spurious valid s%0d", s), 1, 0);
        else begin
          checkVal($sformatf("rdata s%0d", s), rdata[s], expQ[found].data);
          checkVal($sformatf("rdEdge s%0d", s), cyc + 1, expQ[found].due);
          expQ.delete(found);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int op;
    for (int s = 0; s < 3; s++) begin
      rest[s] = 1'b0; addr[s] = '0; be[s] = '0; rd[s] = 1'b0; wr[s] = 1'b0; wdata[s] = '0;
    end
    @(posedge clk); #1;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      checkVal($sformatf("reset valid s%0d", s), 32'(rvalid[s]), 0);
      checkVal($sformatf("reset data s%0d", s), rdata[s], 0);
      checkVal($sformatf("reset wreq s%0d", s), 32'(wreq[s]), 1);
    end
    @(posedge clk); #1;
    for (int s = 0; s < 3; s++) rest[s] = 1'b1;

    for (int s = 0; s < 3; s++)
      for (int w = 0; w < 16; w++) issue(s, 0, 1, 32'(w * 4), 4'hF, $urandom);

    // Full write, read-after-write, partial lanes, empty byte enable, collision.
    issue(0, 0, 1, 32'h10, 4'hF, 32'h11223344);
    issue(0, 1, 0, 32'h10, 4'h0, 32'h0);
    issue(0, 0, 1, 32'h10, 4'h5, 32'hAABBCCDD);
    issue(0, 1, 0, 32'h10, 4'h0, 32'h0);
    issue(0, 0, 1, 32'h10, 4'h0, 32'hFFFFFFFF);
    issue(0, 1, 0, 32'h10, 4'h0, 32'h0);
    issue(0, 1, 1, 32'h18, 4'hF, 32'h01020304);
    issue(0, 1, 0, 32'h18, 4'h0, 32'h0);
    idle(6);

    // Reset with a read in flight and a write presented during reset.
    issue(0, 1, 0, 32'h20, 4'h0, 32'h0);
    rest[0] = 1'b0;
    flush(0);
    addr[0] = 32'h14; be[0] = 4'hF; wdata[0] = 32'hCAFEF00D; wr[0] = 1'b1;
    @(negedge clk);
    checkVal("wreq in reset", 32'(wreq[0]), 1);
    @(posedge clk); #1;
    @(negedge clk);
    checkVal("valid after reset", 32'(rvalid[0]), 0);
    checkVal("data after reset", rdata[0], 0);
    checkVal("wreq held in reset", 32'(wreq[0]), 1);
    @(posedge clk); #1;
    wr[0] = 1'b0; rest[0] = 1'b1;
    idle(4);
    issue(0, 1, 0, 32'h10, 4'h0, 32'h0);
    issue(0, 1, 0, 32'h14, 4'h0, 32'h0);

    // Out-of-range write, then read both the out-of-range and aliased in-range word.
    issue(0, 0, 1, 32'h1010, 4'hF, 32'h55);
    issue(0, 1, 0, 32'h1010, 4'h0, 32'h0);
    issue(0, 1, 0, 32'h10, 4'h0, 32'h0);

    issue(1, 0, 1, 32'h8, 4'hF, 32'h0BADF00D);
    issue(1, 1, 0, 32'h8, 4'h0, 32'h0);

    issue(2, 1, 0, 32'h0, 4'h0, 32'h0);
    issue(2, 1, 0, 32'h4, 4'h0, 32'h0);
    issue(2, 1, 0, 32'h8, 4'h0, 32'h0);
    idle(8);

    for (int s = 0; s < 3; s++) begin
      repeat (150) begin
        op = $urandom_range(0, 19);
        a  = (32'($urandom_range(0, 15)) << 2) | ($urandom & 32'h3);
        if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 255)) << 12);
        if (op < 10)       issue(s, 1, 0, a, 4'h0, 32'h0);
        else if (op < 18)  issue(s, 0, 1, a, 4'($urandom), $urandom);
        else if (op == 18) issue(s, 1, 1, a, 4'($urandom), $urandom);
        else               idle($urandom_range(1, 3));
        if ($urandom_range(0, 3) == 0) idle(1);
      end
      idle(10);
    end

    idle(20);
    checkVal("reads drained", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
